// File: rtl/pe_array_sync_cntl.sv
// rtl/pe_array_sync_cntl.sv - PE array barrier controller with arming, sticky arrival, drain handshake and timeout
module pe_array_sync_cntl #(
  parameter int NUM_PE          = 64,
  parameter int TIMEOUT_WIDTH   = 16,
  parameter int ROUND_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic                       cfg__sync__start,
  input  logic [NUM_PE-1:0]          cfg__sync__peEnableMask,
  input  logic [TIMEOUT_WIDTH-1:0]   cfg__sync__timeout,
  input  logic                       cfg__sync__clearErr,
  input  logic [NUM_PE-1:0]          pe__sys__thisSynchronized,
  output logic                       sys__pe__allSynchronized,
  output logic                       sync__cfg__busy,
  output logic                       sync__cfg__timeoutErr,
  output logic [NUM_PE-1:0]          sync__cfg__missingMask,
  output logic [ROUND_CNT_WIDTH-1:0] sync__cfg__roundCount
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t                     state, state_n;
  logic [NUM_PE-1:0]          mask_r, mask_n;
  logic [NUM_PE-1:0]          arrived_r, arrived_n;
  logic [TIMEOUT_WIDTH-1:0]   timer, timer_n;
  logic                       all_sync_n;
  logic                       busy_n;
  logic                       timeout_err_n;
  logic [NUM_PE-1:0]          missing_n;
  logic [ROUND_CNT_WIDTH-1:0] round_cnt_n;

  logic [NUM_PE-1:0]          pe_masked;
  logic [NUM_PE-1:0]          arrived_now;
  logic                       done;

  // Arrival view for this cycle: sticky history plus any enabled PE high right now
  always_comb begin
    pe_masked   = pe__sys__thisSynchronized & mask_r;
    arrived_now = arrived_r | pe_masked;
    done        = &(arrived_now | ~mask_r);
  end

  // Next-state and next-output logic; every output is the registered copy of these
  always_comb begin
    state_n       = state;
    mask_n        = mask_r;
    arrived_n     = arrived_r;
    timer_n       = timer;
    all_sync_n    = 1'b0;
    timeout_err_n = sync__cfg__timeoutErr;
    missing_n     = sync__cfg__missingMask;
    round_cnt_n   = sync__cfg__roundCount;
    case (state)
      S_IDLE: begin
        if (cfg__sync__start) begin
          state_n   = S_WAIT;
          mask_n    = cfg__sync__peEnableMask;
          arrived_n = '0;
          timer_n   = cfg__sync__timeout;
        end
      end
      S_WAIT: begin
        arrived_n = arrived_now;
        // A zero timer means the timeout is disabled and never reaches 1
        if (timer != '0) begin
          timer_n = timer - TIMEOUT_WIDTH'(1);
        end
        // Completion takes priority over expiry in the same cycle
        if (done) begin
          state_n    = S_RELEASE;
          all_sync_n = 1'b1;
        end else if (timer == TIMEOUT_WIDTH'(1)) begin
          state_n       = S_ERROR;
          timeout_err_n = 1'b1;
          missing_n     = mask_r & ~(arrived_r | pe__sys__thisSynchronized);
        end
      end
      S_RELEASE: begin
        // Hold the broadcast until every enabled PE has dropped its level
        if (pe_masked != '0) begin
          all_sync_n = 1'b1;
        end else begin
          state_n     = S_IDLE;
          round_cnt_n = sync__cfg__roundCount + ROUND_CNT_WIDTH'(1);
        end
      end
      S_ERROR: begin
        if (cfg__sync__clearErr) begin
          state_n       = S_IDLE;
          timeout_err_n = 1'b0;
          missing_n     = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State, round context and registered outputs
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state                    <= S_IDLE;
      mask_r                   <= '0;
      arrived_r                <= '0;
      timer                    <= '0;
      sys__pe__allSynchronized <= 1'b0;
      sync__cfg__busy          <= 1'b0;
      sync__cfg__timeoutErr    <= 1'b0;
      sync__cfg__missingMask   <= '0;
      sync__cfg__roundCount    <= '0;
    end else begin
      state                    <= state_n;
      mask_r                   <= mask_n;
      arrived_r                <= arrived_n;
      timer                    <= timer_n;
      sys__pe__allSynchronized <= all_sync_n;
      sync__cfg__busy          <= busy_n;
      sync__cfg__timeoutErr    <= timeout_err_n;
      sync__cfg__missingMask   <= missing_n;
      sync__cfg__roundCount    <= round_cnt_n;
    end
  end

endmodule

// File: tb/tb_pe_array_sync_cntl.sv
// tb/tb_pe_array_sync_cntl.sv - self-checking bench for pe_array_sync_cntl
module tb_pe_array_sync_cntl;

  logic        clk = 1'b0;
  logic        reset_poweron;
  logic        start;
  logic [3:0]  en_mask;
  logic [15:0] timeout;
  logic        clear_err;
  logic [3:0]  pe_sync;
  logic        all_sync;
  logic        busy;
  logic        timeout_err;
  logic [3:0]  missing;
  logic [1:0]  round_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        start;
    logic [3:0]  mask;
    logic [15:0] tmo;
    logic        clr;
    logic [3:0]  pes;
    logic        e_all;
    logic        e_busy;
    logic        e_err;
    logic [3:0]  e_miss;
    logic [1:0]  e_rc;
  } vec_t;

  vec_t vecs[$];

  pe_array_sync_cntl #(
    .NUM_PE(4),
    .TIMEOUT_WIDTH(16),
    .ROUND_CNT_WIDTH(2)
  ) u_dut (
    .clk(clk),
    .reset_poweron(reset_poweron),
    .cfg__sync__start(start),
    .cfg__sync__peEnableMask(en_mask),
    .cfg__sync__timeout(timeout),
    .cfg__sync__clearErr(clear_err),
    .pe__sys__thisSynchronized(pe_sync),
    .sys__pe__allSynchronized(all_sync),
    .sync__cfg__busy(busy),
    .sync__cfg__timeoutErr(timeout_err),
    .sync__cfg__missingMask(missing),
    .sync__cfg__roundCount(round_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_all, input logic e_busy,
                           input logic e_err, input logic [3:0] e_miss, input logic [1:0] e_rc);
    check({tag, "_all"},  {31'd0, all_sync},    {31'd0, e_all});
    check({tag, "_busy"}, {31'd0, busy},        {31'd0, e_busy});
    check({tag, "_err"},  {31'd0, timeout_err}, {31'd0, e_err});
    check({tag, "_miss"}, {28'd0, missing},     {28'd0, e_miss});
    check({tag, "_rc"},   {30'd0, round_cnt},   {30'd0, e_rc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic av(input logic s, input logic [3:0] m, input logic [15:0] t, input logic c,
                    input logic [3:0] p, input logic ea, input logic eb, input logic ee,
                    input logic [3:0] em, input logic [1:0] er);
    vec_t v;
    v.start = s; v.mask = m; v.tmo = t; v.clr = c; v.pes = p;
    v.e_all = ea; v.e_busy = eb; v.e_err = ee; v.e_miss = em; v.e_rc = er;
    vecs.push_back(v);
  endtask

  initial begin
    // Inputs applied for one cycle; expected outputs are those visible after that edge
    // Full mask, staggered arrivals at cycles 3,5,7,9, drop at 12
    av(1, 4'hF, 0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h0, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h1, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h1, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h3, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h3, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h7, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h7, 0, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'hF, 1, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'hF, 1, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'hF, 1, 1, 0, 4'h0, 0);
    av(0, 4'hF, 0, 0, 4'h0, 0, 0, 0, 4'h0, 1);
    // Mask 0101 with noise on PE1/PE3; PE0 early and sticky
    av(1, 4'h5, 0, 0, 4'hA, 0, 1, 0, 4'h0, 1);
    av(0, 4'h5, 0, 0, 4'hB, 0, 1, 0, 4'h0, 1);
    av(0, 4'h5, 0, 0, 4'h2, 0, 1, 0, 4'h0, 1);
    av(0, 4'h5, 0, 0, 4'hC, 1, 1, 0, 4'h0, 1);
    av(0, 4'h5, 0, 0, 4'h6, 1, 1, 0, 4'h0, 1);
    av(0, 4'h5, 0, 0, 4'hA, 0, 0, 0, 4'h0, 2);
    // PE1 one-cycle early pulse still counts
    av(1, 4'hF, 0, 0, 4'h0, 0, 1, 0, 4'h0, 2);
    av(0, 4'hF, 0, 0, 4'h2, 0, 1, 0, 4'h0, 2);
    av(0, 4'hF, 0, 0, 4'h0, 0, 1, 0, 4'h0, 2);
    av(0, 4'hF, 0, 0, 4'hD, 1, 1, 0, 4'h0, 2);
    av(0, 4'hF, 0, 0, 4'h0, 0, 0, 0, 4'h0, 3);
    // Completion on the timer==1 cycle wins over expiry; round count wraps to 0
    av(1, 4'h3, 3, 0, 4'h0, 0, 1, 0, 4'h0, 3);
    av(0, 4'h3, 3, 0, 4'h0, 0, 1, 0, 4'h0, 3);
    av(0, 4'h3, 3, 0, 4'h1, 0, 1, 0, 4'h0, 3);
    av(0, 4'h3, 3, 0, 4'h3, 1, 1, 0, 4'h0, 3);
    av(0, 4'h3, 3, 0, 4'h0, 0, 0, 0, 4'h0, 0);
    // Empty mask: single one-cycle pulse, unmasked PEs ignored
    av(1, 4'h0, 0, 0, 4'hF, 0, 1, 0, 4'h0, 0);
    av(0, 4'h0, 0, 0, 4'hF, 1, 1, 0, 4'h0, 0);
    av(0, 4'h0, 0, 0, 4'hF, 0, 0, 0, 4'h0, 1);

    reset_poweron = 1'b1;
    start = 0; en_mask = 0; timeout = 0; clear_err = 0; pe_sync = 0;
    #12;
    check_all("reset", 0, 0, 0, 4'h0, 0);
    reset_poweron = 1'b0;

    foreach (vecs[i]) begin
      start = vecs[i].start; en_mask = vecs[i].mask; timeout = vecs[i].tmo;
      clear_err = vecs[i].clr; pe_sync = vecs[i].pes;
      tick();
      check_all($sformatf("v%0d", i), vecs[i].e_all, vecs[i].e_busy, vecs[i].e_err,
                vecs[i].e_miss, vecs[i].e_rc);
    end

    // Timeout 20 with PE3 absent
    start = 1; en_mask = 4'hF; timeout = 16'd20; pe_sync = 4'h0;
    tick();
    start = 0; pe_sync = 4'h7;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("tmo_err_%0d", i), {31'd0, timeout_err}, {31'd0, (i == 20)});
      check($sformatf("tmo_all_%0d", i), {31'd0, all_sync}, 32'd0);
    end
    check_all("tmo_hit", 0, 1, 1, 4'h8, 1);
    start = 1;
    tick();
    check_all("tmo_start_ign", 0, 1, 1, 4'h8, 1);
    clear_err = 1;
    tick();
    check_all("tmo_clear", 0, 0, 0, 4'h0, 1);
    start = 0; clear_err = 0; pe_sync = 4'h0;
    tick();
    check_all("tmo_idle", 0, 0, 0, 4'h0, 1);

    // Asynchronous reset mid-WAIT
    start = 1; en_mask = 4'hF; timeout = 0;
    tick();
    start = 0;
    check("mw_busy", {31'd0, busy}, 32'd1);
    #2 reset_poweron = 1'b1;
    #1 check_all("mw_reset", 0, 0, 0, 4'h0, 0);
    reset_poweron = 1'b0;

    // Asynchronous reset mid-RELEASE
    start = 1; en_mask = 4'h1; pe_sync = 4'h0;
    tick();
    start = 0; pe_sync = 4'h1;
    tick();
    check("mr_all", {31'd0, all_sync}, 32'd1);
    #2 reset_poweron = 1'b1;
    #1 check_all("mr_reset", 0, 0, 0, 4'h0, 0);
    reset_poweron = 1'b0;
    pe_sync = 4'h0;

    // Five empty rounds from reset: 1,2,3,0,1
    for (int r = 1; r <= 5; r++) begin
      start = 1; en_mask = 4'h0;
      tick();
      start = 0;
      tick();
      check($sformatf("wrap_pulse_%0d", r), {31'd0, all_sync}, 32'd1);
      tick();
      check($sformatf("wrap_low_%0d", r), {31'd0, all_sync}, 32'd0);
      check($sformatf("wrap_rc_%0d", r), {30'd0, round_cnt}, r % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_array_sync_cntl.md
Name: pe_array_sync_cntl

Overview:
Array-level barrier controller for the PE array, with a parametrised PE count.
- Collects each PE's per-round completion level (pe__sys__thisSynchronized) under a per-round enable mask and drives the single broadcast sys__pe__allSynchronized.
- Adds four things the plain wire-AND aggregation lacks: explicit round arming, a sticky arrival vector, a release/drain handshake, and timeout detection that reports which PEs are missing.

Parameters:
NUM_PE, 64, number of PEs in the array; width of all per-PE vectors
TIMEOUT_WIDTH, 16, width of the timeout load value and down-counter
ROUND_CNT_WIDTH, 16, width of the completed-round counter

Ports:
clk  input  1  system clock
reset_poweron  input  1  asynchronous active-high reset
cfg__sync__start  input  1  one-cycle pulse; arms a new sync round
cfg__sync__peEnableMask  input  NUM_PE  PEs participating; sampled on an accepted start
cfg__sync__timeout  input  TIMEOUT_WIDTH  timeout in cycles, sampled on start; 0 disables the timeout
cfg__sync__clearErr  input  1  pulse; clears the error state
pe__sys__thisSynchronized  input  NUM_PE  per-PE level: this PE's streams are complete
sys__pe__allSynchronized  output  1  broadcast level: all enabled PEs are synchronized
sync__cfg__busy  output  1  high in every state except IDLE
sync__cfg__timeoutErr  output  1  high while in ERROR
sync__cfg__missingMask  output  NUM_PE  enabled PEs that had not arrived at timeout
sync__cfg__roundCount  output  ROUND_CNT_WIDTH  number of completed rounds; wraps modulo 2^ROUND_CNT_WIDTH

Behaviour:
- Reset (asynchronous, any state): state=IDLE; every output 0; internal mask_r, arrived_r and timer all 0.
- All outputs are registered. There is no combinational input-to-output path.
- States: IDLE, WAIT, RELEASE, ERROR.
- IDLE:
  - start=1 -> WAIT next cycle.
  - On that same edge: mask_r<=peEnableMask, arrived_r<=0, timer<=timeout.
- WAIT:
  - Each cycle: arrived_r <= arrived_r | (thisSynchronized & mask_r). Arrival is sticky, so a PE that drops its level early still counts.
  - done = &(arrived_r | (thisSynchronized & mask_r) | ~mask_r).
  - done=1 -> RELEASE next cycle; allSynchronized goes high on that edge.
  - Latency: the last enabled PE asserts in cycle n -> allSynchronized=1 in cycle n+1.
  - If timeout!=0, timer decrements once per WAIT cycle.
  - timer==1 and done=0 -> ERROR. On that edge: missingMask <= mask_r & ~(arrived_r | thisSynchronized), timeoutErr<=1.
  - Result: timeout T with no arrivals gives timeoutErr=1 exactly T cycles after WAIT entry.
  - done and timeout expiry in the same cycle: done wins, go to RELEASE.
- RELEASE:
  - allSynchronized is held at 1 while (thisSynchronized & mask_r) != 0. This is the drain handshake: each PE deasserts its level after seeing the broadcast.
  - When (thisSynchronized & mask_r)==0: next cycle allSynchronized=0, roundCount+1, state=IDLE.
  - Minimum RELEASE residency is 1 cycle.
- ERROR:
  - allSynchronized=0; timeoutErr and missingMask are held.
  - clearErr=1 -> IDLE next cycle; timeoutErr<=0, missingMask<=0.
  - roundCount is not incremented.
- start is ignored in WAIT, RELEASE and ERROR, including start together with clearErr in ERROR.
- Empty mask (start with mask=0):
  - WAIT for 1 cycle, done immediately.
  - RELEASE for 1 cycle.
  - allSynchronized forms a 1-cycle pulse; roundCount+1.
- Bits of thisSynchronized outside mask_r are ignored in every state.
- A PE already high at start counts as arrived in the first WAIT cycle.
- roundCount wraps from all-ones to 0.

Test Plan:
1. NUM_PE=4, mask=4'b1111, timeout=0; PEs assert in cycles 3,5,7,9 after start -> allSynchronized rises in cycle 10; all PEs drop in cycle 12 -> allSynchronized falls in cycle 13; roundCount=1, busy=0.
2. mask=4'b0101; only PE0 and PE2 assert; PE1 and PE3 toggle randomly -> release depends only on PE0/PE2; PE1 activity during RELEASE does not extend allSynchronized.
3. mask=4'b1111, timeout=20; PE0-2 assert, PE3 never asserts -> timeoutErr=1 at WAIT+20, missingMask=4'b1000, allSynchronized stays 0; start during ERROR is ignored; clearErr -> IDLE with missingMask=0 and roundCount unchanged.
4. Completion and expiry in the same cycle (last PE asserts on the timer==1 cycle) -> RELEASE with timeoutErr=0. Separately: mask=0 start -> exactly one 1-cycle allSynchronized pulse, roundCount+1.
5. Sticky arrival: PE1 pulses high for 1 cycle early, then stays low -> still counted, release occurs when the others arrive. Separately: assert reset_poweron mid-WAIT and mid-RELEASE -> all outputs 0 immediately, without waiting for a clk edge.
6. ROUND_CNT_WIDTH=2; run 5 empty-mask rounds -> roundCount sequence 1,2,3,0,1.
